// File: rtl/dll_pkg.sv
// dll_pkg: shared sequence-number types, modulo arithmetic and replay FSM states
package dll_pkg;
    localparam int SEQ_MOD = 4096;
    localparam int SEQ_W = $clog2(SEQ_MOD);
    typedef logic [SEQ_W-1:0] seq_t;
    typedef enum logic [1:0] {IDLE, REPLAY_REQ, REPLAYING} replay_st_t;
    function automatic seq_t seq_diff(input seq_t a, input seq_t b);
        return a - b;
    endfunction
endpackage

// File: rtl/dll_replay_timer.sv
// dll_replay_timer: replay timer with stop, restart, start-when-stopped, hold and expiry strobe
module dll_replay_timer #(
    parameter int TIMEOUT = 711,
    parameter int TMR_W = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_stop,
    input  logic i_restart,
    input  logic i_start,
    input  logic i_hold,
    output logic o_expire
);
    logic [TMR_W-1:0] r_cnt;
    logic             r_run;
    // strobes on the cycle whose edge takes the count to TIMEOUT
    assign o_expire = r_run & ~i_hold & (r_cnt == TMR_W'(TIMEOUT - 1));
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_stop) begin
            r_cnt <= '0;
            r_run <= 1'b0;
        end else if (i_restart || (i_start && !r_run)) begin
            r_cnt <= '0;
            r_run <= 1'b1;
        end else if (r_run && !i_hold) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/dll_tx_seq_replay_ctrl.sv
// dll_tx_seq_replay_ctrl: TX DLL sequence assignment, Ack/Nak processing and replay control
module dll_tx_seq_replay_ctrl
    import dll_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 64,
    parameter int REPLAY_TIMEOUT = 711,
    parameter int TMR_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_dl_down,
    input  logic             i_tlp_req,
    output logic             o_tlp_gnt,
    output logic [SEQ_W-1:0] o_seq_num,
    input  logic             i_tlp_sent,
    input  logic             i_dllp_vld,
    input  logic             i_dllp_is_nak,
    input  logic [SEQ_W-1:0] i_dllp_seq,
    output logic             o_purge_vld,
    output logic [SEQ_W-1:0] o_purge_cnt,
    output logic             o_replay_start,
    input  logic             i_replay_done,
    output logic             o_replaying,
    output logic             o_retrain_req,
    output logic             o_dllp_err
);
    replay_st_t r_st, w_st_nxt;
    seq_t       r_nts, r_ackd, r_purge_cnt;
    seq_t       w_outst, w_rem, w_d;
    logic [1:0] r_replay_num;
    logic       r_purge_vld, r_dllp_err;
    logic       w_valid, w_fwd, w_nak_rpl, w_expire;

    assign w_outst   = seq_diff(r_nts, r_ackd + 1'b1);
    // entries still unacked once this Ack/Nak is applied
    assign w_rem     = seq_diff(r_nts, i_dllp_seq + 1'b1);
    assign w_d       = seq_diff(i_dllp_seq, r_ackd);
    assign w_valid   = i_dllp_vld & ~i_dl_down & (w_rem <= w_outst);
    assign w_fwd     = w_valid & (w_d != '0);
    assign w_nak_rpl = w_valid & i_dllp_is_nak & (r_st == IDLE) & (w_rem != '0);

    assign o_tlp_gnt      = i_tlp_req & (r_st == IDLE) & ~i_dl_down & (w_outst < SEQ_W'(MAX_OUTSTANDING));
    assign o_seq_num      = r_nts;
    assign o_purge_vld    = r_purge_vld;
    assign o_purge_cnt    = r_purge_cnt;
    assign o_dllp_err     = r_dllp_err;
    assign o_replay_start = r_st == REPLAY_REQ;
    assign o_replaying    = r_st == REPLAYING;
    assign o_retrain_req  = o_replay_start & (r_replay_num == 2'd3);

    dll_replay_timer #(.TIMEOUT(REPLAY_TIMEOUT), .TMR_W(TMR_W)) u_tmr (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_stop    (i_dl_down | (w_fwd & (w_rem == '0))),
        .i_restart ((w_fwd & (w_rem != '0)) | ((r_st == REPLAYING) & i_replay_done)),
        .i_start   (i_tlp_sent & (w_outst != '0)),
        .i_hold    (r_st != IDLE),
        .o_expire  (w_expire)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_st <= IDLE;
        else        r_st <= w_st_nxt;
    end

    // forward progress in the same cycle as expiry suppresses the replay
    always_comb begin
        w_st_nxt = r_st;
        if (i_dl_down)               w_st_nxt = IDLE;
        else if (r_st == IDLE)       w_st_nxt = (w_nak_rpl || (w_expire && !w_fwd)) ? REPLAY_REQ : IDLE;
        else if (r_st == REPLAY_REQ) w_st_nxt = REPLAYING;
        else if (i_replay_done)      w_st_nxt = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nts        <= '0;
            r_ackd       <= '1;
            r_replay_num <= '0;
            r_purge_vld  <= 1'b0;
            r_purge_cnt  <= '0;
            r_dllp_err   <= 1'b0;
        end else if (i_dl_down) begin
            r_nts        <= '0;
            r_ackd       <= '1;
            r_replay_num <= '0;
            r_purge_vld  <= 1'b0;
            r_purge_cnt  <= '0;
            r_dllp_err   <= 1'b0;
        end else begin
            r_nts        <= o_tlp_gnt ? r_nts + 1'b1 : r_nts;
            r_ackd       <= w_fwd ? i_dllp_seq : r_ackd;
            // two-bit counter rolls 3 -> 0 alongside the retrain request
            r_replay_num <= w_fwd ? '0 : o_replay_start ? r_replay_num + 1'b1 : r_replay_num;
            r_purge_vld  <= w_fwd;
            r_purge_cnt  <= w_fwd ? w_d : '0;
            r_dllp_err   <= i_dllp_vld & ~w_valid;
        end
    end
endmodule

// File: tb/tb_dll_tx_seq_replay_ctrl.sv
// tb_dll_tx_seq_replay_ctrl: vector table plus hand sequences; Ack/Nak responses checked through a scoreboard
module tb_dll_tx_seq_replay_ctrl;
    import dll_pkg::*;
    logic        clk = 1'b0, rst_n = 1'b0;
    logic        i_dl_down = 0, i_tlp_req = 0, i_tlp_sent = 0, i_dllp_vld = 0, i_dllp_is_nak = 0, i_replay_done = 0;
    logic [11:0] i_dllp_seq = '0;
    logic        o_tlp_gnt, o_purge_vld, o_replay_start, o_replaying, o_retrain_req, o_dllp_err;
    logic [11:0] o_seq_num, o_purge_cnt;

    always #5 clk = ~clk;

    dll_tx_seq_replay_ctrl #(.MAX_OUTSTANDING(4), .REPLAY_TIMEOUT(20), .TMR_W(12)) dut (
        .clk(clk), .rst_n(rst_n), .i_dl_down(i_dl_down), .i_tlp_req(i_tlp_req),
        .o_tlp_gnt(o_tlp_gnt), .o_seq_num(o_seq_num), .i_tlp_sent(i_tlp_sent),
        .i_dllp_vld(i_dllp_vld), .i_dllp_is_nak(i_dllp_is_nak), .i_dllp_seq(i_dllp_seq),
        .o_purge_vld(o_purge_vld), .o_purge_cnt(o_purge_cnt), .o_replay_start(o_replay_start),
        .i_replay_done(i_replay_done), .o_replaying(o_replaying), .o_retrain_req(o_retrain_req),
        .o_dllp_err(o_dllp_err)
    );

    typedef struct {int ng; int sq; bit nak; bit pv; int pc; bit err; bit rs;} vec_t;
    typedef struct {bit pv; logic [11:0] pc; bit err;} rsp_t;
    rsp_t q[$];
    vec_t v[12];
    int   total = 0, bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        rsp_t e;
        if (o_purge_vld || o_dllp_err) begin
            if (q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_rsp: purge_vld=%0b cnt=%0d err=%0b want none", o_purge_vld, o_purge_cnt, o_dllp_err);
            end else begin
                e = q.pop_front();
                chk("rsp{pv,cnt,err}", 32'({o_purge_vld, o_purge_cnt, o_dllp_err}), 32'({e.pv, e.pc, e.err}));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        {i_dl_down, i_tlp_req, i_tlp_sent, i_dllp_vld, i_dllp_is_nak, i_replay_done} = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        q.delete();
    endtask

    task automatic grant(input int exp);
        i_tlp_req = 1;
        @(negedge clk);
        chk("gnt", 32'(o_tlp_gnt), 1);
        chk("seq", 32'(o_seq_num), 32'(exp % 4096));
        tick();
        i_tlp_req = 0;
    endtask

    task automatic send(input int sq, input bit nak, input bit pv, input int pc, input bit err);
        rsp_t e;
        i_dllp_vld = 1;
        i_dllp_seq = sq[11:0];
        i_dllp_is_nak = nak;
        e = '{pv, pc[11:0], err};
        if (pv || err) q.push_back(e);
        tick();
        i_dllp_vld = 0;
    endtask

    task automatic wait_rs(output int n);
        n = 0;
        for (int k = 1; k <= 200; k++) begin
            tick();
            n = k;
            if (o_replay_start) break;
        end
    endtask

    task automatic pulse_done();
        i_replay_done = 1;
        tick();
        i_replay_done = 0;
    endtask

    initial begin
        int n;
        v[0]  = '{3, 1,    0, 1, 2, 0, 0};
        v[1]  = '{3, 0,    1, 1, 1, 0, 1};
        v[2]  = '{0, 100,  0, 0, 0, 1, 0};
        v[3]  = '{1, 100,  0, 0, 0, 1, 0};
        v[4]  = '{2, 100,  0, 0, 0, 1, 0};
        v[5]  = '{2, 4095, 0, 0, 0, 0, 0};
        v[6]  = '{2, 4095, 1, 0, 0, 0, 1};
        v[7]  = '{4, 3,    0, 1, 4, 0, 0};
        v[8]  = '{4, 3,    1, 1, 4, 0, 0};
        v[9]  = '{0, 4095, 1, 0, 0, 0, 0};
        v[10] = '{3, 3,    0, 0, 0, 1, 0};
        v[11] = '{4, 4094, 0, 0, 0, 1, 0};

        do_reset();
        @(negedge clk);
        chk("rst_seq", 32'(o_seq_num), 0);
        chk("rst_outs", 32'({o_tlp_gnt, o_purge_vld, o_purge_cnt, o_replay_start, o_replaying, o_retrain_req, o_dllp_err}), 0);
        chk("rst_ackd", 32'(dut.r_ackd), 4095);

        foreach (v[i]) begin
            do_reset();
            for (int g = 0; g < v[i].ng; g++) grant(g);
            send(v[i].sq, v[i].nak, v[i].pv, v[i].pc, v[i].err);
            @(negedge clk);
            chk($sformatf("vec%0d_replay_start", i), 32'(o_replay_start), 32'(v[i].rs));
            tick();
            @(negedge clk);
            chk($sformatf("vec%0d_rsp_seen", i), 32'(q.size()), 0);
        end

        // Ack with one left outstanding keeps the timer running
        do_reset();
        for (int g = 0; g < 3; g++) grant(g);
        i_tlp_sent = 1;
        tick();
        i_tlp_sent = 0;
        send(1, 0, 1, 2, 0);
        @(negedge clk);
        chk("ack_tmr_run", 32'(dut.u_tmr.r_run), 1);
        chk("ack_ackd", 32'(dut.r_ackd), 1);
        wait_rs(n);
        chk("ack_tmr_expiry", 32'(n), 20);

        // Nak blocks grants until replay_done, then seq 3
        do_reset();
        for (int g = 0; g < 3; g++) grant(g);
        send(0, 1, 1, 1, 0);
        @(negedge clk);
        chk("nak_replay_start", 32'(o_replay_start), 1);
        tick();
        i_tlp_req = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("nak_gnt_blocked", 32'({o_tlp_gnt, o_replaying}), 32'(2'b01));
            tick();
        end
        i_replay_done = 1;
        @(negedge clk);
        chk("nak_gnt_done_cycle", 32'(o_tlp_gnt), 0);
        tick();
        i_replay_done = 0;
        @(negedge clk);
        chk("nak_resume", 32'({o_replaying, o_tlp_gnt, o_seq_num}), 32'({1'b0, 1'b1, 12'd3}));
        tick();
        i_tlp_req = 0;

        // successive timeouts, retrain on the fourth
        do_reset();
        grant(0);
        i_tlp_sent = 1;
        tick();
        i_tlp_sent = 0;
        wait_rs(n);
        chk("to1_latency", 32'(n), 20);
        chk("to1_retrain", 32'(o_retrain_req), 0);
        for (int k = 1; k <= 3; k++) begin
            tick();
            pulse_done();
            wait_rs(n);
            chk($sformatf("to%0d_latency", k + 1), 32'(n), 20);
            chk($sformatf("to%0d_retrain", k + 1), 32'(o_retrain_req), 32'(k == 3));
        end
        tick();
        chk("to_replay_num", 32'(dut.r_replay_num), 0);

        // sequence wrap
        do_reset();
        for (int it = 0; it < 2047; it++) begin
            grant(2 * it);
            grant(2 * it + 1);
            send(2 * it + 1, 0, 1, 2, 0);
        end
        for (int g = 4094; g < 4098; g++) grant(g);
        send(0, 0, 1, 3, 0);
        @(negedge clk);
        chk("wrap_ackd", 32'(dut.r_ackd), 0);
        chk("wrap_seq", 32'(o_seq_num), 2);
        tick();
        chk("wrap_rsp_seen", 32'(q.size()), 0);

        // outstanding limit, grant+Ack together, DL_Down mid-replay
        do_reset();
        for (int g = 0; g < 4; g++) grant(g);
        i_tlp_req = 1;
        @(negedge clk);
        chk("max_blocked", 32'(o_tlp_gnt), 0);
        send(0, 0, 1, 1, 0);
        @(negedge clk);
        chk("max_resume", 32'({o_tlp_gnt, o_seq_num}), 32'({1'b1, 12'd4}));
        send(2, 0, 1, 2, 0);
        i_tlp_req = 0;
        @(negedge clk);
        chk("both_seq", 32'(o_seq_num), 5);
        chk("both_ackd", 32'(dut.r_ackd), 2);
        send(3, 1, 1, 1, 0);
        tick();
        @(negedge clk);
        chk("dd_replaying", 32'(o_replaying), 1);
        i_dl_down = 1;
        tick();
        i_dl_down = 0;
        @(negedge clk);
        chk("dd_outs", 32'({o_seq_num, o_replaying, o_purge_vld, o_dllp_err}), 0);
        chk("dd_state", 32'({dut.r_ackd, dut.r_replay_num, dut.u_tmr.r_run}), 32'({12'd4095, 2'd0, 1'b0}));

        // async reset mid-replay
        do_reset();
        grant(0);
        grant(1);
        send(0, 1, 1, 1, 0);
        tick();
        @(negedge clk);
        chk("rr_replaying", 32'(o_replaying), 1);
        #2 rst_n = 0;
        #1;
        chk("rr_async_drop", 32'({o_replaying, o_seq_num}), 0);
        do_reset();
        tick();
        chk("end_rsp_seen", 32'(q.size()), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
